vec_dot_product_pipe: RTL

Parametrised, pipelined successor to the combinational 8-element dot-product blocks. It multiplies N unsigned element pairs per beat and sums them through a registered binary adder tree. It can also accumulate the per-beat sums across a multi-beat packet terminated by in_last. Valid/ready handshakes on both sides let it sit between a vector source stream and a downstream result consumer.

---
 rtl/vec_dot_product_pipe.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/vec_dot_product_pipe.sv
// ---------------------------------------------------------------------------
// vec_dot_product_pipe
//
// Pipelined unsigned dot product of two NUM_ELEMENTS-wide vectors per beat.
// Each beat's element products go through a registered binary adder tree.
// The resulting beat sums are accumulated across a packet that ends with
// in_last. Valid/ready handshakes are used on both the input and output side.
//
// Pipeline: P (products) -> A1..AL (adder tree, L = log2(NUM_ELEMENTS))
//           -> O (accumulator + result register).
// The whole pipeline advances together (adv = !out_valid || out_ready).
// It is never partially stalled.
//
// Optional build macro:
//   VEC_DOT_PIPE_SAT_EN  - when defined, the accumulator saturates at
//                          2^ACC_WIDTH-1 instead of wrapping. In both builds
//                          out_ovf flags any accumulation that exceeded
//                          ACC_WIDTH.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept a beat
//   in_vec_a   in   packed elements, element i at [i*ELEMENT_WIDTH +: ELEMENT_WIDTH]
//   in_vec_b   in   same packing as in_vec_a
//   in_last    in   final beat of packet
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_data   out  packet dot product (ACC_WIDTH bits)
//   out_ovf    out  accumulation exceeded ACC_WIDTH during the packet
// ---------------------------------------------------------------------------
module vec_dot_product_pipe #(
    parameter int NUM_ELEMENTS  = 8,
    parameter int ELEMENT_WIDTH = 8,
    parameter int ACC_WIDTH     = 2*ELEMENT_WIDTH + $clog2(NUM_ELEMENTS) + 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_vec_a,
    input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_vec_b,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ACC_WIDTH-1:0]                  out_data,
    output logic                                  out_ovf
);

    localparam int L     = $clog2(NUM_ELEMENTS);
    localparam int PW    = 2*ELEMENT_WIDTH;
    localparam int SUM_W = PW + L;

    // Adds a beat sum to the accumulator. Returns {overflow, new value}.
    // The overflow bit is the true carry-out, so it is the same in both builds.
    function automatic logic [ACC_WIDTH:0] acc_add(
        input logic [ACC_WIDTH-1:0] a,
        input logic [SUM_W-1:0]     b
    );
        logic [ACC_WIDTH:0] full;
        full = {1'b0, a} + (ACC_WIDTH+1)'(b);
`ifdef VEC_DOT_PIPE_SAT_EN
        if (full[ACC_WIDTH]) full[ACC_WIDTH-1:0] = '1;
`endif
        return full;
    endfunction

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---- Stage P: element products -------------------------------------
    logic [PW-1:0] prod_p0 [NUM_ELEMENTS];
    logic          vld_p0;
    logic          last_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0  <= in_valid;
            last_p0 <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                prod_p0[i] <= PW'(in_vec_a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH])
                            * PW'(in_vec_b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]);
            end
        end
    end

    // ---- Stages A1..AL: adder tree, each level one bit wider (exact) ----
    for (genvar k = 1; k <= L; k++) begin : tree
        localparam int W   = PW + k;
        localparam int CNT = NUM_ELEMENTS >> k;

        logic [W-1:0] sum [CNT];
        logic         vld;
        logic         last;

        if (k == 1) begin : g_src
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld  <= 1'b0;
                    last <= 1'b0;
                end else if (adv) begin
                    vld  <= vld_p0;
                    last <= last_p0;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    for (int i = 0; i < CNT; i++) begin
                        sum[i] <= W'(prod_p0[2*i]) + W'(prod_p0[2*i+1]);
                    end
                end
            end
        end else begin : g_src
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld  <= 1'b0;
                    last <= 1'b0;
                end else if (adv) begin
                    vld  <= tree[k-1].vld;
                    last <= tree[k-1].last;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    for (int i = 0; i < CNT; i++) begin
                        sum[i] <= W'(tree[k-1].sum[2*i]) + W'(tree[k-1].sum[2*i+1]);
                    end
                end
            end
        end
    end

    // ---- Stage O: packet accumulator and result register ----------------
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_acc;
    logic [ACC_WIDTH:0]   acc_nxt;

    always_comb begin
        acc_nxt = acc_add(acc, tree[L].sum[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            // With adv high, a held result is either being consumed or absent.
            // So out_valid simply follows whether a packet completes now.
            out_valid <= tree[L].vld && tree[L].last;
            if (tree[L].vld) begin
                if (tree[L].last) begin
                    out_data <= acc_nxt[ACC_WIDTH-1:0];
                    out_ovf  <= ovf_acc | acc_nxt[ACC_WIDTH];
                    acc      <= '0;
                    ovf_acc  <= 1'b0;
                end else begin
                    acc      <= acc_nxt[ACC_WIDTH-1:0];
                    ovf_acc  <= ovf_acc | acc_nxt[ACC_WIDTH];
                end
            end
        end
    end

endmodule
